alu_writeback: RTL and testbench

Writeback and status stage directly downstream of the 16-bit ALU. It accepts one ALU result per handshake, together with the result's flags and destination register. It latches the architectural status flags and queues register-file writes in a small FIFO, so a stalled register-file write port never loses an ALU result. It also evaluates branch conditions from the latched flags and counts retired ALU operations.

---
 rtl/alu_wb_pkg.sv | 30 +++
 rtl/wb_fifo.sv | 55 +++++
 rtl/alu_writeback.sv | 122 ++++++++++++
 tb/tb_alu_writeback.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_wb_pkg.sv
// Shared opcode, branch-condition and flag-index definitions for the ALU writeback stage.
package alu_wb_pkg;

  localparam logic [5:0] OP_ADD = 6'b001001;
  localparam logic [5:0] OP_CMP = 6'b010111;
  localparam logic [5:0] OP_DEC = 6'b011010;
  localparam logic [5:0] OP_MIN = OP_ADD;
  localparam logic [5:0] OP_MAX = OP_DEC;

  typedef enum logic [2:0] {
    COND_AL = 3'd0,
    COND_EQ = 3'd1,
    COND_NE = 3'd2,
    COND_CS = 3'd3,
    COND_CC = 3'd4,
    COND_MI = 3'd5,
    COND_VS = 3'd6,
    COND_NV = 3'd7
  } cond_e;

  localparam int FLAG_ZF = 3;
  localparam int FLAG_CF = 2;
  localparam int FLAG_NF = 1;
  localparam int FLAG_OF = 0;

  function automatic logic isLegalOp(input logic [5:0] op);
    return (op >= OP_MIN) && (op <= OP_MAX);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding pending register-file writes, with an extra read port on the youngest entry.
module wb_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [WIDTH-1:0] youngest_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wrPtr_q, rdPtr_q;
  logic [PTR_W-1:0] youngIdx;
  logic             doPush, doPop;

  assign doPush = push_i && !full_o;
  assign doPop  = pop_i && !empty_o;

  // Storage is cleared on reset so the head read port shows zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q[PTR_W-1:0]] <= wdata_i;
        wrPtr_q <= wrPtr_q + (PTR_W+1)'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + (PTR_W+1)'(1);
      end
    end
  end

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign full_o  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                   (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign empty_o = (wrPtr_q == rdPtr_q);

  assign youngIdx   = wrPtr_q[PTR_W-1:0] - PTR_W'(1);
  assign rdata_o    = mem_q[rdPtr_q[PTR_W-1:0]];
  assign youngest_o = mem_q[youngIdx];

endmodule

// File: rtl/alu_writeback.sv
// Writeback/status stage after the 16-bit ALU: latches flags, queues register writes, evaluates branches.
// Define ALU_WB_BYPASS_EN to expose the youngest queued write for operand forwarding.
module alu_writeback
  import alu_wb_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            in_opcode,
  input  logic [DATA_W:0]       in_result,
  input  logic [3:0]            in_flags,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic [3:0]            flags_q,
  input  logic [2:0]            cond_sel,
  output logic                  cond_true,
  output logic                  illegal_op,
`ifdef ALU_WB_BYPASS_EN
  output logic                  byp_valid,
  output logic [REG_ADDR_W-1:0] byp_addr,
  output logic [DATA_W-1:0]     byp_data,
`endif
  output logic [15:0]           retired_cnt
);

  localparam int ENTRY_W = REG_ADDR_W + DATA_W;

  logic               accept, legalOp, pushEn, popEn;
  logic               fifoFull, fifoEmpty;
  logic [ENTRY_W-1:0] headEntry, youngEntry;
  logic [3:0]         flags_d;
  logic               illegal_d;
  logic [15:0]        retired_d;
  logic               unusedCarry;

  // The carry-out bit already lives in CF, so it never reaches the register file.
  assign unusedCarry = in_result[DATA_W];

  assign accept  = in_valid && in_ready;
  assign legalOp = isLegalOp(in_opcode);
  assign pushEn  = accept && legalOp && (in_opcode != OP_CMP);
  assign popEn   = wb_valid && wb_ready;

  wb_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (pushEn),
    .pop_i     (popEn),
    .wdata_i   ({in_rd, in_result[DATA_W-1:0]}),
    .rdata_o   (headEntry),
    .youngest_o(youngEntry),
    .full_o    (fifoFull),
    .empty_o   (fifoEmpty)
  );

  assign in_ready = !fifoFull;
  assign wb_valid = !fifoEmpty;
  assign wb_addr  = headEntry[ENTRY_W-1:DATA_W];
  assign wb_data  = headEntry[DATA_W-1:0];

`ifdef ALU_WB_BYPASS_EN
  assign byp_valid = !fifoEmpty;
  assign byp_addr  = youngEntry[ENTRY_W-1:DATA_W];
  assign byp_data  = youngEntry[DATA_W-1:0];
`else
  logic [ENTRY_W-1:0] unusedYoung;
  assign unusedYoung = youngEntry;
`endif

  always_comb begin
    flags_d   = flags_q;
    illegal_d = illegal_op;
    retired_d = retired_cnt;
    if (accept) begin
      retired_d = retired_cnt + 16'd1;
      if (legalOp) begin
        flags_d = in_flags;
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q     <= '0;
      illegal_op  <= 1'b0;
      retired_cnt <= '0;
    end else begin
      flags_q     <= flags_d;
      illegal_op  <= illegal_d;
      retired_cnt <= retired_d;
    end
  end

  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(cond_sel))
      COND_AL: cond_true = 1'b1;
      COND_EQ: cond_true = flags_q[FLAG_ZF];
      COND_NE: cond_true = !flags_q[FLAG_ZF];
      COND_CS: cond_true = flags_q[FLAG_CF];
      COND_CC: cond_true = !flags_q[FLAG_CF];
      COND_MI: cond_true = flags_q[FLAG_NF];
      COND_VS: cond_true = flags_q[FLAG_OF];
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus randomized traffic against a queue-based model.
module tb_alu_writeback;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [16:0] in_result;
  logic [3:0]  in_flags;
  logic [3:0]  in_rd;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [3:0]  flags_q;
  logic [2:0]  cond_sel;
  logic        cond_true;
  logic        illegal_op;
  logic [15:0] retired_cnt;
`ifdef ALU_WB_BYPASS_EN
  logic        byp_valid;
  logic [3:0]  byp_addr;
  logic [15:0] byp_data;
`endif

  alu_writeback #(
    .DATA_W(16),
    .REG_ADDR_W(4),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_result  (in_result),
    .in_flags   (in_flags),
    .in_rd      (in_rd),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .flags_q    (flags_q),
    .cond_sel   (cond_sel),
    .cond_true  (cond_true),
    .illegal_op (illegal_op),
`ifdef ALU_WB_BYPASS_EN
    .byp_valid  (byp_valid),
    .byp_addr   (byp_addr),
    .byp_data   (byp_data),
`endif
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: pending writes as a plain queue of {rd, data}.
  logic [19:0] mq[$];
  logic [3:0]  mFlags   = '0;
  logic        mIllegal = 1'b0;
  logic [15:0] mCnt     = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic condModel(input logic [2:0] sel, input logic [3:0] f);
    case (sel)
      3'd0: return 1'b1;
      3'd1: return f[3];
      3'd2: return !f[3];
      3'd3: return f[2];
      3'd4: return !f[2];
      3'd5: return f[1];
      3'd6: return f[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic legalModel(input logic [5:0] op);
    return (int'(op) >= 9) && (int'(op) <= 26);
  endfunction

  task automatic compareModel();
    checkOutput("inReady", in_ready, mq.size() < DEPTH);
    checkOutput("wbValid", wb_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      checkOutput("wbAddr", wb_addr, mq[0][19:16]);
      checkOutput("wbData", wb_data, mq[0][15:0]);
    end
    checkOutput("flags", flags_q, mFlags);
    checkOutput("illegal", illegal_op, mIllegal);
    checkOutput("retired", retired_cnt, mCnt);
    checkOutput("condTrue", cond_true, condModel(cond_sel, mFlags));
`ifdef ALU_WB_BYPASS_EN
    checkOutput("bypValid", byp_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      checkOutput("bypAddr", byp_addr, mq[mq.size()-1][19:16]);
      checkOutput("bypData", byp_data, mq[mq.size()-1][15:0]);
    end
`endif
  endtask

  // One clock: check at the falling edge, then advance the model at the rising edge.
  task automatic step();
    bit acc, pop;
    @(negedge clk);
    compareModel();
    acc = in_valid && (mq.size() < DEPTH);
    pop = wb_ready && (mq.size() != 0);
    @(posedge clk);
    if (pop) mq.delete(0);
    if (acc) begin
      mCnt++;
      if (legalModel(in_opcode)) begin
        mFlags = in_flags;
        if (in_opcode != 6'b010111) mq.push_back({in_rd, in_result[15:0]});
      end else begin
        mIllegal = 1'b1;
      end
    end
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [16:0] res,
                               input logic [3:0] fl, input logic [3:0] rd, input logic wr,
                               input logic [2:0] sel);
    in_valid  = v;
    in_opcode = op;
    in_result = res;
    in_flags  = fl;
    in_rd     = rd;
    wb_ready  = wr;
    cond_sel  = sel;
    step();
  endtask

  localparam logic [5:0] ADD = 6'b001001;
  localparam logic [5:0] CMP = 6'b010111;

  initial begin
    rst = 1'b1;
    in_valid = 0; in_opcode = 0; in_result = 0; in_flags = 0; in_rd = 0;
    wb_ready = 0; cond_sel = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstWbValid", wb_valid, 0);
    checkOutput("rstInReady", in_ready, 1);
    checkOutput("rstRetired", retired_cnt, 0);
    checkOutput("rstWbData", wb_data, 0);
    rst = 1'b0;

    // First ADD appears one cycle after acceptance.
    applyStimulus(1, ADD, 17'h00013, 4'b0000, 4'd3, 1, 0);
    checkOutput("addWbValid", wb_valid, 1);
    checkOutput("addWbAddr", wb_addr, 3);
    checkOutput("addWbData", wb_data, 16'h0013);
    checkOutput("addRetired", retired_cnt, 1);

    // CMP updates flags only.
    applyStimulus(1, CMP, 17'h00001, 4'b0010, 4'd5, 1, 5);
    checkOutput("cmpFlags", flags_q, 4'b0010);
    checkOutput("cmpNoWb", wb_valid, 0);
    checkOutput("cmpMi", cond_true, 1);
    cond_sel = 3'd1;
    #1 checkOutput("cmpEq", cond_true, 0);

    // Backpressure: third ADD waits, no pass-through on the popping cycle.
    applyStimulus(1, ADD, 17'h00101, 4'b0000, 4'd1, 0, 0);
    applyStimulus(1, ADD, 17'h00202, 4'b0000, 4'd2, 0, 0);
    checkOutput("bpFull", in_ready, 0);
    applyStimulus(1, ADD, 17'h00404, 4'b0000, 4'd4, 0, 0);
    applyStimulus(1, ADD, 17'h00404, 4'b0000, 4'd4, 1, 0);
    checkOutput("bpHeadAfterPop", wb_addr, 2);
    applyStimulus(1, ADD, 17'h00404, 4'b0000, 4'd4, 0, 0);
    checkOutput("bpThirdTaken", retired_cnt, 5);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 1, 0);

    // Carry-out is dropped from write data but kept in CF.
    applyStimulus(1, ADD, 17'h10000, 4'b1100, 4'd7, 0, 3);
    checkOutput("carryData", wb_data, 16'h0000);
    checkOutput("carryFlags", flags_q, 4'b1100);
    checkOutput("carryCs", cond_true, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);

    // Illegal opcode is sticky, leaves flags alone, still retires.
    applyStimulus(1, 6'b000000, 17'h0ABCD, 4'b1111, 4'd9, 1, 0);
    checkOutput("illSticky", illegal_op, 1);
    checkOutput("illFlags", flags_q, 4'b1100);
    checkOutput("illNoWb", wb_valid, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("illHold", illegal_op, 1);

    // Randomized traffic, biased towards legal opcodes.
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(9, 26));
      applyStimulus($urandom_range(0, 9) < 7, op, 17'($urandom), 4'($urandom), 4'($urandom),
                    $urandom_range(0, 3) != 0, 3'($urandom));
    end

    // Asynchronous reset with two entries queued.
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, ADD, 17'h01111, 4'b0001, 4'd6, 0, 0);
    applyStimulus(1, ADD, 17'h02222, 4'b0001, 4'd8, 0, 0);
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    checkOutput("arstWbValid", wb_valid, 0);
    checkOutput("arstInReady", in_ready, 1);
    checkOutput("arstRetired", retired_cnt, 0);
    checkOutput("arstFlags", flags_q, 0);
    checkOutput("arstIllegal", illegal_op, 0);
    checkOutput("arstWbAddr", wb_addr, 0);
    checkOutput("arstWbData", wb_data, 0);
`ifdef ALU_WB_BYPASS_EN
    checkOutput("arstBypValid", byp_valid, 0);
`endif
    mq.delete();
    mFlags = '0;
    mIllegal = 1'b0;
    mCnt = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1, ADD, 17'h00055, 4'b0100, 4'd2, 1, 4);
    applyStimulus(0, 0, 0, 0, 0, 1, 4);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
